// File: rtl/combo_sweep_ctrl_pkg.sv
// combo_pkg: shared constants and types for the combinational sweep sequencer.
//   - FSM state encodings (ST_IDLE..ST_DONE) and the matching enum type
//   - default input count and settle time
//   - truth-table width helper (2**n_in)
// Ports: none (package).
package combo_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_DRIVE  = ST_DRIVE,
      S_SAMPLE = ST_SAMPLE,
      S_DONE   = ST_DONE
   } state_t;

   localparam int N_IN_DEF   = 3;
   localparam int SETTLE_DEF = 2;
   // Settle counter width; covers the legal settle range 1..15.
   localparam int SETTLE_W   = 4;

   // Number of rows in the truth table for n inputs.
   function automatic int table_w(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/combo_sweep_ctrl_if.sv
// combo_sweep_ctrl_if: control/observation bundle between the control side
// (bench or CPU register block plus the combinational block under test) and
// the sweep sequencer.
//   start     control -> sequencer   request a sweep
//   q_in      block   -> sequencer   Q output of the combinational block
//   vec_out   sequencer -> block     input vector (A = MSB ... C = LSB)
//   busy      sequencer -> control   sweep in progress
//   done      sequencer -> control   one-cycle completion pulse
//   table_out sequencer -> control   captured truth table
//   pass      sequencer -> control   table_out matched the golden table
//   fail_idx  sequencer -> control   first failing vector (COMBO_SWEEP_STOP_ON_FAIL_EN only)
// Handshake: start is a level request sampled only while the sequencer is
// idle; there is no ready signal, a start seen while busy or in the done
// cycle is dropped. done is a single-cycle pulse; table_out and pass are
// valid in that cycle and held until the next accepted start.
// Modports: slave = sequencer side, master = control side.
interface combo_sweep_ctrl_if
   import combo_pkg::*;
#(
   parameter int N_IN = N_IN_DEF
);
   localparam int TW = table_w(N_IN);

   logic            start;
   logic            q_in;
   logic [N_IN-1:0] vec_out;
   logic            busy;
   logic            done;
   logic [TW-1:0]   table_out;
   logic            pass;
`ifdef COMBO_SWEEP_STOP_ON_FAIL_EN
   logic [N_IN-1:0] fail_idx;
`endif

   modport slave (
      input  start,
      input  q_in,
      output vec_out,
      output busy,
      output done,
      output table_out,
`ifdef COMBO_SWEEP_STOP_ON_FAIL_EN
      output fail_idx,
`endif
      output pass
   );

   modport master (
      output start,
      output q_in,
      input  vec_out,
      input  busy,
      input  done,
      input  table_out,
`ifdef COMBO_SWEEP_STOP_ON_FAIL_EN
      input  fail_idx,
`endif
      input  pass
   );

endinterface

// File: rtl/combo_sweep_ctrl_settle_timer.sv
// combo_settle_timer: settle-window down-counter.
//   clk    in   clock
//   rst    in   synchronous active-high reset (count -> 0)
//   load   in   load SETTLE-1 (takes priority over en)
//   en     in   decrement while non-zero
//   expire out  count is zero: the current cycle is the last of the window
// Loading SETTLE-1 and holding en gives a window of exactly SETTLE cycles,
// the last of which has expire high.
module combo_settle_timer
   import combo_pkg::*;
#(
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire
);

   logic [SETTLE_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= SETTLE_W'(SETTLE - 1);
      end else if (en && (count != '0)) begin
         count <= count - SETTLE_W'(1);
      end
   end

   assign expire = (count == '0);

endmodule

// File: rtl/combo_sweep_ctrl.sv
// combo_sweep_ctrl: self-test sequencer for an N_IN-input combinational block.
// On an accepted start it drives every input vector 0..2**N_IN-1 in turn,
// holds each for SETTLE cycles, samples Q in one extra cycle, builds the truth
// table and compares it with EXPECTED.
//   clk        in   clock, all state on the rising edge
//   rst        in   synchronous active-high reset
//   bus        slave modport of combo_sweep_ctrl_if (start, q_in, vec_out,
//              busy, done, table_out, pass, and fail_idx when enabled)
//   dbg_state  out  current FSM state (combo_pkg ST_* encoding)
// Optional feature macro: COMBO_SWEEP_STOP_ON_FAIL_EN -- stop the sweep at
// the first vector whose Q differs from EXPECTED and report it on fail_idx.
module combo_sweep_ctrl
   import combo_pkg::*;
#(
   parameter int                  N_IN     = N_IN_DEF,
   parameter int                  SETTLE   = SETTLE_DEF,
   parameter logic [2**N_IN-1:0]  EXPECTED = '0
) (
   input  logic                clk,
   input  logic                rst,
   combo_sweep_ctrl_if.slave   bus,
   output logic [1:0]          dbg_state
);

   localparam int TW = table_w(N_IN);
   localparam logic [TW-1:0] GOLDEN = EXPECTED;

   if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("combo_sweep_ctrl: SETTLE must be in 1..15");
   end

   state_t          state_q, state_d;
   logic [N_IN-1:0] idx_q;
   logic [N_IN-1:0] vec_q;
   logic [TW-1:0]   tbl_q;
   logic [TW-1:0]   tbl_next;
   logic            pass_q;
   logic            last_idx;
   logic            stop_now;

   // FSM strobes
   logic accept;
   logic tmr_load;
   logic tmr_en;
   logic sample;
   logic tmr_expire;

   combo_settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (tmr_load),
      .en     (tmr_en),
      .expire (tmr_expire)
   );

   // Table with the current sample merged in; used both for the register
   // update and for the pass compare so the final sample is included.
   always_comb begin
      tbl_next        = tbl_q;
      tbl_next[idx_q] = bus.q_in;
   end

   assign last_idx = &idx_q;

`ifdef COMBO_SWEEP_STOP_ON_FAIL_EN
   logic [N_IN-1:0] fail_idx_q;
   assign stop_now     = (bus.q_in != GOLDEN[idx_q]);
   assign bus.fail_idx = fail_idx_q;
`else
   assign stop_now = 1'b0;
`endif

   // ---------------- FSM state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM next state / strobes ----------------
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      sample   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               accept   = 1'b1;
               tmr_load = 1'b1;
               state_d  = S_DRIVE;
            end
         end
         S_DRIVE: begin
            tmr_en = 1'b1;
            if (tmr_expire) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            sample = 1'b1;
            if (last_idx || stop_now) begin
               state_d = S_DONE;
            end else begin
               tmr_load = 1'b1;
               state_d  = S_DRIVE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         vec_q  <= '0;
         tbl_q  <= '0;
         pass_q <= 1'b0;
      end else if (accept) begin
         idx_q  <= '0;
         vec_q  <= '0;
         tbl_q  <= '0;
         pass_q <= 1'b0;
      end else if (sample) begin
         tbl_q <= tbl_next;
         if (last_idx || stop_now) begin
            // Leaving for DONE: release the block inputs and settle verdict.
            vec_q  <= '0;
            pass_q <= (tbl_next == GOLDEN);
         end else begin
            // vec_out moves with idx on the edge that re-enters DRIVE.
            idx_q <= idx_q + N_IN'(1);
            vec_q <= idx_q + N_IN'(1);
         end
      end
   end

`ifdef COMBO_SWEEP_STOP_ON_FAIL_EN
   always_ff @(posedge clk) begin
      if (rst || accept) begin
         fail_idx_q <= '0;
      end else if (sample && stop_now) begin
         fail_idx_q <= idx_q;
      end
   end
`endif

   assign bus.vec_out   = vec_q;
   assign bus.table_out = tbl_q;
   assign bus.pass      = pass_q;
   assign bus.busy      = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
   assign bus.done      = (state_q == S_DONE);
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_combo_sweep_ctrl.sv
// tb_combo_sweep_ctrl: directed bench for combo_sweep_ctrl.
// Two sequencers share start/rst; both see a majority-gate block model.
// dut_a has the matching golden table (8'hE8), dut_b a wrong one (8'hE9).
module tb_combo_sweep_ctrl;
   import combo_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   combo_sweep_ctrl_if #(.N_IN(3)) bus_a ();
   combo_sweep_ctrl_if #(.N_IN(3)) bus_b ();
   logic [1:0] st_a, st_b;

   function automatic logic maj(input logic [2:0] v);
      return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
   endfunction

   assign bus_a.start = start;
   assign bus_b.start = start;
   assign bus_a.q_in  = maj(bus_a.vec_out);
   assign bus_b.q_in  = maj(bus_b.vec_out);

   combo_sweep_ctrl #(.N_IN(3), .SETTLE(2), .EXPECTED(8'hE8)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_a.slave),
      .dbg_state (st_a)
   );

   combo_sweep_ctrl #(.N_IN(3), .SETTLE(2), .EXPECTED(8'hE9)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_b.slave),
      .dbg_state (st_b)
   );

   // ---------------- vector table ----------------
   typedef struct {
      logic       start;
      logic [2:0] vec;
      logic       busy;
      logic       done;
      logic [7:0] tbl;
      logic       pass;
   } rec_t;

   rec_t recs [1:25];

   // ---------------- driver / checker tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Accept a sweep, then walk cycles 1..25 against the table.
   task automatic run_sweep(input bit pulses);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         check($sformatf("a_vec c%0d", c),  32'(bus_a.vec_out),   32'(recs[c].vec));
         check($sformatf("a_busy c%0d", c), 32'(bus_a.busy),      32'(recs[c].busy));
         check($sformatf("a_done c%0d", c), 32'(bus_a.done),      32'(recs[c].done));
         check($sformatf("a_tbl c%0d", c),  32'(bus_a.table_out), 32'(recs[c].tbl));
         check($sformatf("a_pass c%0d", c), 32'(bus_a.pass),      32'(recs[c].pass));
`ifdef COMBO_SWEEP_STOP_ON_FAIL_EN
         if (c <= 4) begin
            check($sformatf("b_done c%0d", c), 32'(bus_b.done), 32'(c == 4));
         end
         if (c == 4) begin
            check("b_tbl_stop",  32'(bus_b.table_out), 32'h00);
            check("b_pass_stop", 32'(bus_b.pass),      32'h0);
            check("b_fail_idx",  32'(bus_b.fail_idx),  32'h0);
         end
`else
         check($sformatf("b_done c%0d", c), 32'(bus_b.done), 32'(c == 25));
         if (c == 25) begin
            check("b_tbl",  32'(bus_b.table_out), 32'hE8);
            check("b_pass", 32'(bus_b.pass),      32'h0);
         end
`endif
         start = pulses ? recs[c].start : 1'b0;
         tick();
      end
      start = 1'b0;
      check("a_state_after", 32'(st_a), 32'(ST_IDLE));
      for (int k = 0; k < 5; k++) begin
         check($sformatf("a_done_after %0d", k), 32'(bus_a.done), 32'h0);
         check($sformatf("a_busy_after %0d", k), 32'(bus_a.busy), 32'h0);
         tick();
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int dones;

      for (int c = 1; c <= 25; c++) begin
         int ns;
         ns = (c <= 24) ? (c - 1) / 3 : 8;
         recs[c].start = (c == 5) || (c == 24);
         recs[c].vec   = (c <= 24) ? 3'((c - 1) / 3) : 3'd0;
         recs[c].busy  = (c <= 24);
         recs[c].done  = (c == 25);
         recs[c].tbl   = 8'hE8 & 8'((1 << ns) - 1);
         recs[c].pass  = (c == 25);
      end

      // Reset, with start asserted while still in reset.
      rst = 1'b1;
      tick();
      tick();
      start = 1'b1;
      tick();
      check("rst_vec",   32'(bus_a.vec_out),   32'h0);
      check("rst_busy",  32'(bus_a.busy),      32'h0);
      check("rst_done",  32'(bus_a.done),      32'h0);
      check("rst_tbl",   32'(bus_a.table_out), 32'h0);
      check("rst_pass",  32'(bus_a.pass),      32'h0);
      check("rst_state", 32'(st_a),            32'(ST_IDLE));
`ifdef COMBO_SWEEP_STOP_ON_FAIL_EN
      check("rst_fail_idx", 32'(bus_b.fail_idx), 32'h0);
`endif
      start = 1'b0;
      rst   = 1'b0;
      tick();
      check("idle_busy", 32'(bus_a.busy), 32'h0);

      // Full sweep with ignored start pulses at cycles 5 and 24.
      run_sweep(1'b1);

      // Reset mid-sweep at cycle 10.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      check("mid_busy_before", 32'(bus_a.busy), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_state", 32'(st_a),            32'(ST_IDLE));
      check("mid_tbl",   32'(bus_a.table_out), 32'h0);
      check("mid_busy",  32'(bus_a.busy),      32'h0);
      check("mid_vec",   32'(bus_a.vec_out),   32'h0);
      dones = 0;
      for (int k = 0; k < 30; k++) begin
         if (bus_a.done) dones++;
         tick();
      end
      check("mid_no_done", 32'(dones), 32'h0);

      // Clean sweep after the abandoned one.
      run_sweep(1'b0);

      // Back-to-back: start held high across two sweeps.
      start = 1'b1;
      tick();
      n = 1;
      while (!bus_a.done && n < 40) begin
         tick();
         n++;
      end
      check("b2b_lat1",  32'(n),          32'd25);
      check("b2b_pass1", 32'(bus_a.pass), 32'h1);
      tick();
      check("b2b_done_fall", 32'(bus_a.done), 32'h0);
      check("b2b_busy_gap",  32'(bus_a.busy), 32'h0);
      tick();
      check("b2b_busy2",  32'(bus_a.busy), 32'h1);
      check("b2b_pass_clr", 32'(bus_a.pass), 32'h0);
      check("b2b_tbl_clr",  32'(bus_a.table_out), 32'h0);
      start = 1'b0;
      n = 1;
      while (!bus_a.done && n < 40) begin
         tick();
         n++;
      end
      check("b2b_lat2",  32'(n),               32'd25);
      check("b2b_pass2", 32'(bus_a.pass),      32'h1);
      check("b2b_tbl2",  32'(bus_a.table_out), 32'hE8);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time guard.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/combo_sweep_ctrl.md
Name: combo_sweep_ctrl

Overview:
Self-test sequencer for the 3-input combinational block (A, B, C -> Q). On a start pulse it steps the block's inputs through every input combination and waits a settle time for each. It then samples Q and builds the full truth table, which it compares against a parameterised golden table. It sits between a bench/CPU-side control register and the combinational block, and owns the block's inputs while busy.

Parameters:
N_IN, 3, number of combinational inputs driven (vec_out width); table width is 2**N_IN
SETTLE, 2, cycles each vector is held before Q is sampled; legal range 1..15
EXPECTED, 8'h00, golden truth table, 2**N_IN bits; bit i = expected Q for input vector i

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a sweep; sampled only in IDLE
q_in  in  1  Q output of the combinational block
vec_out  out  N_IN  input vector to the block; bit N_IN-1 = A ... bit 0 = C
busy  out  1  high from the cycle after start is accepted until done
done  out  1  single-cycle pulse when the sweep completes
table_out  out  2**N_IN  captured truth table; bit i = Q sampled with vec_out == i
pass  out  1  table_out == EXPECTED; valid when done pulses, held until next accepted start

Behaviour:
- Reset (rst high at the edge): state IDLE; vec_out=0, busy=0, done=0, table_out=0, pass=0, idx=0, settle count=0. Applies at any point, including mid-sweep. The sweep is abandoned with no done pulse.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: start=1 -> DRIVE. Set idx=0, vec_out=0, settle count=0, table_out=0, pass=0, busy=1. start=0 -> stay.
- DRIVE: vec_out=idx. Increment settle count each cycle. When count==SETTLE-1 -> SAMPLE.
- SAMPLE: table_out[idx] <= q_in.
  - If idx == 2**N_IN-1 -> DONE.
  - Else idx+1 -> DRIVE with settle count=0; vec_out updates to the new idx on the same edge.
- DONE: done=1 for exactly one cycle, busy=0. pass <= (table_out including the final sample == EXPECTED). vec_out returns to 0. -> IDLE.
- Latency: each vector occupies SETTLE+1 cycles. done is high 2**N_IN*(SETTLE+1)+1 cycles after the edge that accepted start (25 cycles for the defaults).
- start while busy or in DONE: ignored, with no queuing. start held high continuously: a new sweep begins in the cycle after DONE returns to IDLE.
- Wrap-around: idx is N_IN bits wide and never wraps inside a sweep; the last index ends the sweep.
- vec_out changes only on entry to DRIVE. It is stable through the whole SETTLE window and the SAMPLE cycle.
- table_out bits not yet sampled read 0 during a sweep.

Optional Feature:
COMBO_SWEEP_STOP_ON_FAIL_EN
- Defined:
  - Adds output fail_idx [N_IN-1:0], reset to 0.
  - In SAMPLE, if q_in != EXPECTED[idx]: record fail_idx=idx, write that table bit, go directly to DONE with pass=0. Remaining table bits stay 0.
  - fail_idx holds until the next accepted start, which clears it to 0.
- Undefined:
  - No fail_idx port.
  - The sweep always runs all vectors.
  - pass is computed only at DONE.

Decomposition:
- Shared package combo_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_SAMPLE=2'd2, ST_DONE=2'd3
  - default N_IN and SETTLE constants
  - the truth-table width expression
- One sub-module is natural: combo_settle_timer.
  - A SETTLE-cycle down-counter with load, enable and an expire output.
  - Reused by later sequencers.

Test Plan:
- Reset: rst high for 2 cycles, then start=1 with rst still high -> all outputs 0, busy stays 0.
- Full sweep, bench models Q=majority(A,B,C), EXPECTED=8'hE8, SETTLE=2 -> vec_out steps 0..7, each held 3 cycles. done pulses 25 cycles after start. table_out=8'hE8, pass=1.
- Mismatch, same DUT model, EXPECTED=8'hE9 -> table_out=8'hE8, pass=0. With COMBO_SWEEP_STOP_ON_FAIL_EN: done at cycle 4 (after vector 0), fail_idx=0, table_out=8'h00.
- Start during sweep: pulse start at cycles 5 and 24 -> ignored, exactly one done pulse at cycle 25.
- Reset mid-sweep: rst at cycle 10 -> next cycle state IDLE, table_out=0, busy=0, no done. A following start runs a clean 25-cycle sweep.
- Back-to-back: start held high -> second sweep's busy rises the cycle after done falls. pass is cleared at the second start and valid again at the second done.
